// File: rtl/alu_uart_ctrl_if.sv
// Handshake bundle between the UART byte stream, the ALU and the frame controller.
// The controller takes the slave side; the UART/ALU environment drives the master side.
interface alu_uart_ctrl_if #(
    parameter int NB_DATA = 8,
    parameter int NB_OP   = 6
) ();
    logic [NB_DATA-1:0] i_rx_data;
    logic               i_rx_done;
    logic [NB_DATA-1:0] i_alu_result;
    logic               i_tx_done;
    logic [NB_DATA-1:0] o_data_a;
    logic [NB_DATA-1:0] o_data_b;
    logic [NB_OP-1:0]   o_operation;
    logic [NB_DATA-1:0] o_tx_data;
    logic               o_tx_start;
    logic               o_busy;
    logic               o_error;

    modport slave (
        input  i_rx_data, i_rx_done, i_alu_result, i_tx_done,
        output o_data_a, o_data_b, o_operation, o_tx_data, o_tx_start, o_busy, o_error
    );

    modport master (
        output i_rx_data, i_rx_done, i_alu_result, i_tx_done,
        input  o_data_a, o_data_b, o_operation, o_tx_data, o_tx_start, o_busy, o_error
    );
endinterface

// File: rtl/alu_uart_ctrl.sv
// Collects operand A, operand B and opcode bytes from the UART receiver, holds them as
// stable ALU inputs, and hands the captured ALU result to the UART transmitter.
module alu_uart_ctrl #(
    parameter int NB_DATA     = 8,
    parameter int NB_OP       = 6,
    parameter int TIMEOUT_CYC = 1000000
) (
    input  logic              i_clock,
    input  logic              i_reset,
    alu_uart_ctrl_if.slave    bus
);
    localparam int CW = (TIMEOUT_CYC > 0) ? $clog2(TIMEOUT_CYC + 1) : 1;
    localparam logic [CW-1:0] TIMEOUT_LAST = CW'(TIMEOUT_CYC - 1);
    localparam logic [CW-1:0] CNT_MAX      = '1;

    typedef enum logic [2:0] {
        S_WAIT_A,
        S_WAIT_B,
        S_WAIT_OP,
        S_EXEC,
        S_TX_WAIT
    } state_t;

    state_t             state, state_next;
    logic [CW-1:0]      cnt, cnt_next;
    logic [NB_DATA-1:0] data_a, data_a_next;
    logic [NB_DATA-1:0] data_b, data_b_next;
    logic [NB_OP-1:0]   operation, operation_next;
    logic [NB_DATA-1:0] tx_data, tx_data_next;
    logic               tx_start, tx_start_next;
    logic               error, error_next;

    always_ff @(posedge i_clock) begin
        if (!i_reset) begin
            state     <= S_WAIT_A;
            cnt       <= '0;
            data_a    <= '0;
            data_b    <= '0;
            operation <= '0;
            tx_data   <= '0;
            tx_start  <= 1'b0;
            error     <= 1'b0;
        end else begin
            state     <= state_next;
            cnt       <= cnt_next;
            data_a    <= data_a_next;
            data_b    <= data_b_next;
            operation <= operation_next;
            tx_data   <= tx_data_next;
            tx_start  <= tx_start_next;
            error     <= error_next;
        end
    end

    always_comb begin
        state_next     = state;
        cnt_next       = '0;
        data_a_next    = data_a;
        data_b_next    = data_b;
        operation_next = operation;
        tx_data_next   = tx_data;
        tx_start_next  = 1'b0;
        error_next     = 1'b0;

        case (state)
            S_WAIT_A: begin
                if (bus.i_rx_done) begin
                    data_a_next = bus.i_rx_data;
                    state_next  = S_WAIT_B;
                end
            end
            S_WAIT_B, S_WAIT_OP: begin
                // An arriving byte beats a timeout that would fire on the same edge.
                if (bus.i_rx_done) begin
                    if (state == S_WAIT_B) begin
                        data_b_next = bus.i_rx_data;
                        state_next  = S_WAIT_OP;
                    end else begin
                        operation_next = bus.i_rx_data[NB_OP-1:0];
                        state_next     = S_EXEC;
                    end
                end else if (TIMEOUT_CYC != 0 && cnt == TIMEOUT_LAST) begin
                    state_next = S_WAIT_A;
                    error_next = 1'b1;
                end else if (cnt != CNT_MAX) begin
                    cnt_next = cnt + CW'(1);
                end else begin
                    cnt_next = cnt;
                end
            end
            S_EXEC: begin
                tx_data_next  = bus.i_alu_result;
                tx_start_next = 1'b1;
                error_next    = bus.i_rx_done;
                state_next    = S_TX_WAIT;
            end
            S_TX_WAIT: begin
                error_next = bus.i_rx_done;
                if (bus.i_tx_done) begin
                    state_next = S_WAIT_A;
                end
            end
            default: begin
                state_next = S_WAIT_A;
            end
        endcase
    end

    assign bus.o_data_a    = data_a;
    assign bus.o_data_b    = data_b;
    assign bus.o_operation = operation;
    assign bus.o_tx_data   = tx_data;
    assign bus.o_tx_start  = tx_start;
    assign bus.o_error     = error;
    assign bus.o_busy      = (state == S_EXEC) || (state == S_TX_WAIT);
endmodule
